// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with in-order multi-beat line refill.
// Defining ICACHE_FLUSH_EN adds a flush port that invalidates every line.
module icache #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] addr,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_FLUSH_EN
    ,
    input  logic        flush
`endif
);
    localparam int unsigned OB = $clog2(WORDS);
    localparam int unsigned IB = $clog2(LINES);
    localparam int unsigned TW = 32 - OB - IB - 2;
    localparam logic [OB-1:0] BEAT_LAST = OB'(WORDS - 1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t          state, state_nxt;
    logic [LINES-1:0] valid_bit;
    logic [TW-1:0]   tag_mem  [LINES];
    logic [31:0]     data_mem [LINES][WORDS];
    logic [TW-1:0]   req_tag;
    logic [IB-1:0]   req_index;
    logic [OB-1:0]   beat;
    logic            flush_pend;
    logic            flush_i;
    logic [OB-1:0]   off;
    logic [IB-1:0]   idx;
    logic [TW-1:0]   tg;
    logic            hit;
    logic            start;
    logic            last_ack;
    logic            unused_addr_bits;

`ifdef ICACHE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign unused_addr_bits = ^addr[1:0];

    always_comb begin
        off   = addr[OB+1:2];
        idx   = addr[IB+OB+1:OB+2];
        tg    = addr[31:IB+OB+2];
        hit   = valid && (state == IDLE) && valid_bit[idx] && (tag_mem[idx] == tg);
        ready = hit && !flush_i;
        rdata = ready ? data_mem[idx][off] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_addr  = '0;
        start     = 1'b0;
        last_ack  = 1'b0;
        case (state)
            IDLE: begin
                // flush wins over a same-cycle miss
                if (valid && !hit && !flush_i) begin
                    start     = 1'b1;
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_index, beat, 2'b00};
                if (mem_ack && (beat == BEAT_LAST)) begin
                    last_ack  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_bit  <= '0;
            beat       <= '0;
            req_tag    <= '0;
            req_index  <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (start) begin
                req_tag    <= tg;
                req_index  <= idx;
                beat       <= '0;
                flush_pend <= 1'b0;
            end
            if (state == REFILL && mem_ack) begin
                beat <= beat + OB'(1);
            end
            // A flush seen at any point of a refill keeps the refilled line invalid
            if (flush_i) begin
                valid_bit <= '0;
                if (state == REFILL && !last_ack) begin
                    flush_pend <= 1'b1;
                end
            end else if (last_ack && !flush_pend) begin
                valid_bit[req_index] <= 1'b1;
            end
            if (last_ack) begin
                flush_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == REFILL && mem_ack) begin
            data_mem[req_index][beat] <= mem_rdata;
            if (beat == BEAT_LAST) begin
                tag_mem[req_index] <= req_tag;
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized traffic
// checked against a line-level model in which cached data is simply the memory contents.
module tb_icache;
    localparam int unsigned LINES = 16;
    localparam int unsigned WORDS = 4;
    localparam int unsigned OBT = $clog2(WORDS);
    localparam int unsigned LINE_BYTES = 4 * WORDS;

    logic        clk = 1'b0;
    logic        rst, valid, flush;
    logic [31:0] addr;
    logic        ready, mem_req, mem_ack;
    logic [31:0] rdata, mem_addr, mem_rdata;

    always #5 clk = ~clk;

    icache #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .valid(valid), .addr(addr),
        .ready(ready), .rdata(rdata),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef ICACHE_FLUSH_EN
        , .flush(flush)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // reference model state
    bit          mv [LINES];
    int unsigned mt [LINES];
    bit          m_busy = 1'b0;
    bit          m_fl = 1'b0;
    logic [31:0] m_base = '0;
    int unsigned m_beat = 0;
    logic [31:0] mask = '0;
    int unsigned ack_period = 1;
    int unsigned ack_ctr = 0;

    logic        o_ready, o_req, o_ack;
    logic [31:0] o_rdata, o_maddr;
    logic        e_ready, e_req;
    logic [31:0] e_rdata, e_maddr;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ mask;
    endfunction

    // One clock cycle: respond as memory, sample outputs, predict, advance model.
    task automatic step();
        logic [31:0] cur;
        int unsigned li, tg;
        cur = m_base + 32'(4 * m_beat);
        if (ack_period == 0) mem_ack = m_busy && ($urandom_range(2) == 0);
        else mem_ack = m_busy && (ack_ctr == ack_period - 1);
        mem_rdata = mem_ack ? memfn(cur) : $urandom();
        #1;
        o_ready = ready; o_rdata = rdata; o_req = mem_req; o_maddr = mem_addr; o_ack = mem_ack;
        li = (addr / LINE_BYTES) % LINES;
        tg = addr / (LINE_BYTES * LINES);
        e_req   = m_busy;
        e_maddr = cur;
        e_ready = !m_busy && valid && !flush && mv[li] && (mt[li] == tg);
        e_rdata = e_ready ? memfn({addr[31:2], 2'b00}) : 32'h0;
        if (rst) begin
            foreach (mv[i]) mv[i] = 1'b0;
            m_busy = 1'b0; m_fl = 1'b0; ack_ctr = 0;
        end else if (m_busy) begin
            if (flush) begin
                foreach (mv[i]) mv[i] = 1'b0;
                m_fl = 1'b1;
            end
            if (mem_ack) begin
                ack_ctr = 0;
                m_beat++;
                if (m_beat == WORDS) begin
                    m_busy = 1'b0;
                    if (!m_fl) begin
                        mv[(m_base / LINE_BYTES) % LINES] = 1'b1;
                        mt[(m_base / LINE_BYTES) % LINES] = m_base / (LINE_BYTES * LINES);
                    end
                end
            end else begin
                ack_ctr++;
            end
        end else if (flush) begin
            foreach (mv[i]) mv[i] = 1'b0;
        end else if (valid && !e_ready) begin
            m_busy = 1'b1;
            m_base = addr & ~32'(LINE_BYTES - 1);
            m_beat = 0; m_fl = 1'b0; ack_ctr = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0; flush = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; addr = '0; flush = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        n_checks++;
        if (o_ready !== 1'b0 || o_req !== 1'b0 || o_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL reset: ready/req/rdata got %b/%b/%h want 0/0/00000000", o_ready, o_req, o_rdata);
        end
    endtask

    task automatic test_miss_refill();
        ack_period = 1; valid = 1'b1; addr = 32'h0;
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++;
            if (c < 5 && o_ready !== 1'b0) begin
                n_errors++; $display("FAIL miss_ready c%0d: got %b want 0", c, o_ready);
            end
            if (c >= 1 && c <= 4) begin
                n_checks++;
                if (o_req !== 1'b1 || o_maddr !== 32'(4 * (c - 1))) begin
                    n_errors++;
                    $display("FAIL miss_beat c%0d: req/maddr got %b/%h want 1/%h", c, o_req, o_maddr, 32'(4 * (c - 1)));
                end
            end
            if (c == 5 && (o_ready !== 1'b1 || o_rdata !== 32'h0 || o_req !== 1'b0)) begin
                n_errors++;
                $display("FAIL miss_fill_hit: ready/rdata/req got %b/%h/%b want 1/00000000/0", o_ready, o_rdata, o_req);
            end
        end
    endtask

    task automatic test_hit();
        valid = 1'b1; addr = 32'h8;
        step();
        n_checks++;
        if (o_ready !== 1'b1 || o_rdata !== 32'h8 || o_req !== 1'b0) begin
            n_errors++;
            $display("FAIL hit_0x8: ready/rdata/req got %b/%h/%b want 1/00000008/0", o_ready, o_rdata, o_req);
        end
        for (int w = 0; w < 4; w++) begin
            addr = 32'(4 * w) | 32'($urandom_range(3));
            step();
            n_checks++;
            if (o_ready !== e_ready || o_rdata !== e_rdata || o_req !== 1'b0) begin
                n_errors++;
                $display("FAIL hit_word%0d: ready/rdata got %b/%h want %b/%h", w, o_ready, o_rdata, e_ready, e_rdata);
            end
        end
    endtask

    task automatic test_conflict();
        valid = 1'b1; addr = 32'h100;
        for (int c = 0; c < 16; c++) begin
            if (c == 8) addr = 32'h0;
            step();
            n_checks++;
            if (o_ready !== e_ready || o_rdata !== e_rdata || o_req !== e_req || (e_req && o_maddr !== e_maddr)) begin
                n_errors++;
                $display("FAIL conflict c%0d: ready/rdata/req/maddr got %b/%h/%b/%h want %b/%h/%b/%h",
                         c, o_ready, o_rdata, o_req, o_maddr, e_ready, e_rdata, e_req, e_maddr);
            end
            if (c == 4) begin
                n_checks++;
                if (o_maddr !== 32'h10C) begin
                    n_errors++; $display("FAIL conflict_last_beat: maddr got %h want 0000010c", o_maddr);
                end
            end
            if (c == 8) begin
                n_checks++;
                if (o_ready !== 1'b0) begin
                    n_errors++; $display("FAIL conflict_evict: ready got %b want 0", o_ready);
                end
            end
        end
    endtask

    task automatic test_slow_mem();
        bit          prev_req = 1'b0, prev_ack = 1'b0, saw40 = 1'b0;
        logic [31:0] prev_maddr = '0;
        int unsigned acks0 = 0;
        do_reset();
        ack_period = 3; valid = 1'b1; addr = 32'h0;
        for (int c = 0; c < 40; c++) begin
            if (c == 3) addr = 32'h40;
            step();
            n_checks++;
            if (o_ready !== e_ready || o_rdata !== e_rdata || o_req !== e_req || (e_req && o_maddr !== e_maddr)) begin
                n_errors++;
                $display("FAIL slow c%0d: ready/rdata/req/maddr got %b/%h/%b/%h want %b/%h/%b/%h",
                         c, o_ready, o_rdata, o_req, o_maddr, e_ready, e_rdata, e_req, e_maddr);
            end
            if (o_req && prev_req && !prev_ack) begin
                n_checks++;
                if (o_maddr !== prev_maddr) begin
                    n_errors++; $display("FAIL slow_stable c%0d: maddr got %h want %h", c, o_maddr, prev_maddr);
                end
            end
            if (o_req && o_ack && o_maddr < 32'h10) acks0++;
            if (o_ready && o_rdata === 32'h40) saw40 = 1'b1;
            prev_req = o_req; prev_ack = o_ack; prev_maddr = o_maddr;
        end
        n_checks++;
        if (acks0 != 4 || !saw40) begin
            n_errors++; $display("FAIL slow_complete: acks0/hit40 got %0d/%b want 4/1", acks0, saw40);
        end
        ack_period = 1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ack_period = 1; valid = 1'b1; addr = 32'h0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if (o_req !== 1'b0 || o_ready !== 1'b0) begin
            n_errors++; $display("FAIL rst_mid_idle: req/ready got %b/%b want 0/0", o_req, o_ready);
        end
        step();
        n_checks++;
        if (o_req !== 1'b1 || o_maddr !== 32'h0) begin
            n_errors++; $display("FAIL rst_mid_restart: req/maddr got %b/%h want 1/00000000", o_req, o_maddr);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++;
            if (o_ready !== e_ready || o_rdata !== e_rdata || o_req !== e_req || (e_req && o_maddr !== e_maddr)) begin
                n_errors++;
                $display("FAIL rst_mid c%0d: ready/rdata/req/maddr got %b/%h/%b/%h want %b/%h/%b/%h",
                         c, o_ready, o_rdata, o_req, o_maddr, e_ready, e_rdata, e_req, e_maddr);
            end
        end
    endtask

`ifdef ICACHE_FLUSH_EN
    task automatic test_flush();
        do_reset();
        ack_period = 1; valid = 1'b1; addr = 32'h0;
        for (int c = 0; c < 24; c++) begin
            flush = (c == 6 || c == 15);
            if (c == 13) addr = 32'h200;
            step();
            n_checks++;
            if (o_ready !== e_ready || o_rdata !== e_rdata || o_req !== e_req || (e_req && o_maddr !== e_maddr)) begin
                n_errors++;
                $display("FAIL flush c%0d: ready/rdata/req/maddr got %b/%h/%b/%h want %b/%h/%b/%h",
                         c, o_ready, o_rdata, o_req, o_maddr, e_ready, e_rdata, e_req, e_maddr);
            end
            if (c == 6 || c == 7 || c == 19) begin
                n_checks++;
                if (o_ready !== 1'b0) begin
                    n_errors++; $display("FAIL flush_invalid c%0d: ready got %b want 0", c, o_ready);
                end
            end
        end
        flush = 1'b0;
    endtask
`endif

    task automatic test_random();
        int unsigned tg, li, off;
        mask = $urandom();
        do_reset();
        ack_period = 0;
        for (int c = 0; c < 800; c++) begin
            tg = $urandom_range(2); li = $urandom_range(LINES - 1); off = $urandom_range(WORDS - 1);
            addr  = 32'((tg * LINES + li) * LINE_BYTES + off * 4 + $urandom_range(3));
            valid = ($urandom_range(3) != 0);
            rst   = ($urandom_range(149) == 0);
`ifdef ICACHE_FLUSH_EN
            flush = ($urandom_range(39) == 0);
`endif
            step();
            n_checks++;
            if (o_ready !== e_ready || o_rdata !== e_rdata || o_req !== e_req || (e_req && o_maddr !== e_maddr)) begin
                n_errors++;
                $display("FAIL random c%0d: ready/rdata/req/maddr got %b/%h/%b/%h want %b/%h/%b/%h",
                         c, o_ready, o_rdata, o_req, o_maddr, e_ready, e_rdata, e_req, e_maddr);
            end
        end
        rst = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; addr = '0; flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        foreach (mv[i]) begin mv[i] = 1'b0; mt[i] = 0; end
        @(posedge clk);
        #1;
        test_reset();
        test_miss_refill();
        test_hit();
        test_conflict();
        test_slow_mem();
        test_reset_mid();
`ifdef ICACHE_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
